// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch
//                sequencer: state encoding, opcode field position, HALT
//                opcode and the NOP bubble word.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Opcode field inside the instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;

    // Default opcode that stops fetch
    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPC = 6'h3F;

    // Bubble word loaded into IF/ID on a flush
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // True when the opcode field of an instruction matches the given opcode
    function automatic logic opc_match(input logic [31:0]              instr,
                                       input logic [OPC_MSB-OPC_LSB:0] opc);
        return (instr[OPC_MSB:OPC_LSB] == opc);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl_if
//  Description : Loader write port of the fetch sequencer. The loader is
//                the master; the fetch sequencer is the slave and answers
//                with ld_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int ADDR_W = 10
);
    import fetch_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;

    // Loader side
    modport master (
        output ld_valid,
        output ld_addr,
        output ld_data,
        output ld_done,
        input  ld_ready
    );

    // Fetch sequencer side
    modport slave (
        input  ld_valid,
        input  ld_addr,
        input  ld_data,
        input  ld_done,
        output ld_ready
    );

endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sat_cnt
//  Description : Saturating up-counter with synchronous clear. Holds at
//                all-ones instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc,
    input  wire logic             clr,
    output logic      [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

    // Count events, stop at the maximum value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != C_MAX)) begin
            q <= q + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Boots in LOAD where a loader
//                fills instruction memory, then drives PC enable/select and
//                the IF/ID register controls: taken-branch redirect with a
//                fixed bubble count, load-use stalls and HALT detection.
//                Keeps saturating stall and flush counters for debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int          ADDR_W    = 10,
    parameter int          FLUSH_CYC = 2,
    parameter logic [5:0]  HALT_OPC  = fetch_pkg::HALT_OPC,
    parameter int          CNT_W     = 16
) (
    input  wire logic              clk,
    input  wire logic              rst_n,

    fetch_ctrl_if.slave            ld,

    output logic                   imem_we,
    output logic      [ADDR_W-1:0] imem_waddr,
    output logic      [31:0]       imem_wdata,

    input  wire logic              br_taken,
    input  wire logic [31:0]       br_target,
    input  wire logic              stall_req,
    input  wire logic [31:0]       ir,

    output logic                   pc_en,
    output logic                   pc_sel,
    output logic      [31:0]       npc_alu,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   halted,
    output logic      [CNT_W-1:0]  stall_cnt,
    output logic      [CNT_W-1:0]  flush_cnt
);

    import fetch_pkg::*;

    // Bubble counter only has to hold FLUSH_CYC-1
    localparam int               C_FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [C_FC_W-1:0] C_FC_INIT = C_FC_W'(FLUSH_CYC - 1);
    localparam logic [C_FC_W-1:0] C_FC_ONE  = C_FC_W'(1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic [C_FC_W-1:0] r_fcnt;
    logic [C_FC_W-1:0] w_fcnt_nxt;

    logic w_ld_ready;
    logic w_imem_we;
    logic w_pc_en;
    logic w_pc_sel;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_halted;
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_in_load;
    logic w_is_halt;
    logic w_unused_bits;

    assign w_is_halt = opc_match(ir, HALT_OPC);
    assign w_in_load = (r_state == ST_LOAD);

    // Upper target bits and the non-opcode bits of ir are not needed here
    assign w_unused_bits = ^{br_target[31:ADDR_W], ir[OPC_LSB-1:0]};

    // State and bubble-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Next-state and control decode from state plus same-cycle inputs
    always_comb begin
        w_state_nxt   = r_state;
        w_fcnt_nxt    = r_fcnt;
        w_ld_ready    = 1'b0;
        w_imem_we     = 1'b0;
        w_pc_en       = 1'b0;
        w_pc_sel      = 1'b0;
        w_if_id_en    = 1'b0;
        w_if_id_flush = 1'b0;
        w_halted      = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        if (((r_state == ST_RUN) || (r_state == ST_FLUSH)) && br_taken) begin
            // Redirect wins over stall and halt; the fetched word is a bubble
            w_pc_en       = 1'b1;
            w_pc_sel      = 1'b1;
            w_if_id_en    = 1'b1;
            w_if_id_flush = 1'b1;
            w_flush_inc   = 1'b1;
            if (FLUSH_CYC > 1) begin
                w_state_nxt = ST_FLUSH;
                w_fcnt_nxt  = C_FC_INIT;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    w_ld_ready    = 1'b1;
                    w_imem_we     = ld.ld_valid;
                    w_if_id_flush = 1'b1;
                    if (ld.ld_done) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stall_req) begin
                        w_stall_inc = 1'b1;
                    end else if (w_is_halt) begin
                        // HALT itself still moves into IF/ID
                        w_if_id_en  = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_if_id_en = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path instruction: stall and halt are ignored
                    w_pc_en       = 1'b1;
                    w_if_id_en    = 1'b1;
                    w_if_id_flush = 1'b1;
                    if (r_fcnt <= C_FC_ONE) begin
                        w_state_nxt = ST_RUN;
                        w_fcnt_nxt  = '0;
                    end else begin
                        w_fcnt_nxt  = r_fcnt - C_FC_ONE;
                    end
                end
                ST_HALT: begin
                    w_halted      = 1'b1;
                    w_if_id_flush = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                end
            endcase
        end
    end

    // Every output is forced low while reset is asserted
    assign ld.ld_ready   = rst_n & w_ld_ready;
    assign imem_we       = rst_n & w_imem_we;
    assign imem_waddr    = (rst_n && w_in_load) ? ld.ld_addr : '0;
    assign imem_wdata    = (rst_n && w_in_load) ? ld.ld_data : NOP_WORD;
    assign pc_en         = rst_n & w_pc_en;
    assign pc_sel        = rst_n & w_pc_sel;
    assign npc_alu       = rst_n ? 32'(br_target[ADDR_W-1:0]) : 32'h0;
    assign if_id_en      = rst_n & w_if_id_en;
    assign if_id_flush   = rst_n & w_if_id_flush;
    assign halted        = rst_n & w_halted;

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_stall_inc),
        .clr   (1'b0),
        .q     (stall_cnt)
    );

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_flush_inc),
        .clr   (1'b0),
        .q     (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Directed bench for fetch_ctrl. Two instances share stimulus:
//                one with 4-bit counters (saturation) and one with 16-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ld_valid, ld_done;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        br_taken, stall_req;
    logic [31:0] br_target, ir;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.ADDR_W(10)) lif_a ();
    fetch_ctrl_if #(.ADDR_W(10)) lif_b ();

    assign lif_a.ld_valid = ld_valid;
    assign lif_a.ld_addr  = ld_addr;
    assign lif_a.ld_data  = ld_data;
    assign lif_a.ld_done  = ld_done;
    assign lif_b.ld_valid = ld_valid;
    assign lif_b.ld_addr  = ld_addr;
    assign lif_b.ld_data  = ld_data;
    assign lif_b.ld_done  = ld_done;

    logic        imem_we, pc_en, pc_sel, if_id_en, if_id_flush, halted;
    logic [9:0]  imem_waddr;
    logic [31:0] imem_wdata, npc_alu;
    logic [3:0]  stall_cnt, flush_cnt;

    logic        b_imem_we, b_pc_en, b_pc_sel, b_if_id_en, b_if_id_flush, b_halted;
    logic [9:0]  b_imem_waddr;
    logic [31:0] b_imem_wdata, b_npc_alu;
    logic [15:0] b_stall_cnt, b_flush_cnt;

    fetch_ctrl #(.ADDR_W(10), .FLUSH_CYC(2), .HALT_OPC(6'h3F), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ld(lif_a),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .br_taken(br_taken), .br_target(br_target), .stall_req(stall_req), .ir(ir),
        .pc_en(pc_en), .pc_sel(pc_sel), .npc_alu(npc_alu), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_ctrl #(.ADDR_W(10), .FLUSH_CYC(2), .HALT_OPC(6'h3F), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ld(lif_b),
        .imem_we(b_imem_we), .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata),
        .br_taken(br_taken), .br_target(br_target), .stall_req(stall_req), .ir(ir),
        .pc_en(b_pc_en), .pc_sel(b_pc_sel), .npc_alu(b_npc_alu), .if_id_en(b_if_id_en),
        .if_id_flush(b_if_id_flush), .halted(b_halted),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid  = 1'b0;
        ld_done   = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        br_taken  = 1'b0;
        br_target = '0;
        stall_req = 1'b0;
        ir        = '0;
    endtask

    // Reset, then skip straight to RUN with an empty load
    task automatic reset_and_boot();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        ld_done = 1'b1;
        step();
        ld_done = 1'b0;
    endtask

    task automatic test_reset();
        ld_valid = 1'b1; ld_done = 1'b1; ld_addr = 10'h3A5; ld_data = 32'hDEAD_BEEF;
        br_taken = 1'b1; br_target = 32'h0000_0123; stall_req = 1'b1; ir = 32'hFC00_0000;
        #2;
        checks++;
        if ({lif_a.ld_ready, imem_we, pc_en, pc_sel, if_id_en, if_id_flush, halted} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {lif_a.ld_ready, imem_we, pc_en, pc_sel, if_id_en, if_id_flush, halted});
        end
        checks++;
        if ({imem_waddr, imem_wdata, npc_alu, stall_cnt, flush_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_bus waddr=%h wdata=%h npc=%h sc=%0d fc=%0d want all 0",
                     imem_waddr, imem_wdata, npc_alu, stall_cnt, flush_cnt);
        end
        step();
        step();
        idle_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if (lif_a.ld_ready !== 1'b1 || if_id_flush !== 1'b1 || pc_en !== 1'b0 ||
            if_id_en !== 1'b0 || imem_we !== 1'b0) begin
            failures++;
            $display("FAIL load_entry ready=%b flush=%b pc_en=%b if_id_en=%b we=%b want 1 1 0 0 0",
                     lif_a.ld_ready, if_id_flush, pc_en, if_id_en, imem_we);
        end
        step();
    endtask

    task automatic test_load();
        logic [31:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            exp_data = 32'h11 * (i + 1);
            ld_valid = 1'b1;
            ld_addr  = 10'(i);
            ld_data  = exp_data;
            ld_done  = (i == 3);
            #4;
            checks++;
            if (imem_we !== 1'b1 || imem_waddr !== 10'(i) || imem_wdata !== exp_data ||
                lif_a.ld_ready !== 1'b1 || pc_en !== 1'b0) begin
                failures++;
                $display("FAIL load_word%0d we=%b addr=%h data=%h ready=%b pc_en=%b want 1 %h %h 1 0",
                         i, imem_we, imem_waddr, imem_wdata, lif_a.ld_ready, pc_en, 10'(i), exp_data);
            end
            step();
        end
        idle_inputs();
        #4;
        checks++;
        if (pc_en !== 1'b1 || pc_sel !== 1'b0 || if_id_en !== 1'b1 || if_id_flush !== 1'b0 ||
            imem_we !== 1'b0 || lif_a.ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_entry pc_en=%b sel=%b en=%b flush=%b we=%b ready=%b want 1 0 1 0 0 0",
                     pc_en, pc_sel, if_id_en, if_id_flush, imem_we, lif_a.ld_ready);
        end
        step();
    endtask

    task automatic test_branch();
        br_taken = 1'b1; br_target = 32'h0000_0123;
        #4;
        checks++;
        if (pc_en !== 1'b1 || pc_sel !== 1'b1 || npc_alu !== 32'h123 || if_id_flush !== 1'b1) begin
            failures++;
            $display("FAIL branch_redirect pc_en=%b sel=%b npc=%h flush=%b want 1 1 00000123 1",
                     pc_en, pc_sel, npc_alu, if_id_flush);
        end
        step();
        // Wrong-path cycle: HALT opcode and stall must both be ignored
        br_taken = 1'b0; ir = 32'hFC00_0000; stall_req = 1'b1;
        #4;
        checks++;
        if (pc_en !== 1'b1 || pc_sel !== 1'b0 || if_id_flush !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL branch_flush pc_en=%b sel=%b flush=%b halted=%b want 1 0 1 0",
                     pc_en, pc_sel, if_id_flush, halted);
        end
        step();
        ir = '0; stall_req = 1'b0;
        #4;
        checks++;
        if (pc_en !== 1'b1 || if_id_flush !== 1'b0 || halted !== 1'b0 ||
            flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL branch_return pc_en=%b flush=%b halted=%b fc=%0d sc=%0d want 1 0 0 1 0",
                     pc_en, if_id_flush, halted, flush_cnt, stall_cnt);
        end
        step();
        // Upper target bits are dropped; a branch during FLUSH restarts the bubbles
        br_taken = 1'b1; br_target = 32'hABCD_E523;
        #4;
        checks++;
        if (npc_alu !== 32'h0000_0123 || pc_sel !== 1'b1) begin
            failures++;
            $display("FAIL branch_mask npc=%h sel=%b want 00000123 1", npc_alu, pc_sel);
        end
        step();
        br_target = 32'h0000_0055;
        #4;
        checks++;
        if (pc_sel !== 1'b1 || npc_alu !== 32'h55 || if_id_flush !== 1'b1) begin
            failures++;
            $display("FAIL branch_in_flush sel=%b npc=%h flush=%b want 1 00000055 1",
                     pc_sel, npc_alu, if_id_flush);
        end
        step();
        br_taken = 1'b0;
        #4;
        checks++;
        if (if_id_flush !== 1'b1 || pc_sel !== 1'b0) begin
            failures++;
            $display("FAIL branch_restart flush=%b sel=%b want 1 0", if_id_flush, pc_sel);
        end
        step();
        #4;
        checks++;
        if (if_id_flush !== 1'b0 || flush_cnt !== 4'd3) begin
            failures++;
            $display("FAIL branch_count flush=%b fc=%0d want 0 3", if_id_flush, flush_cnt);
        end
        step();
    endtask

    task automatic test_stall();
        reset_and_boot();
        stall_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (pc_en !== 1'b0 || if_id_en !== 1'b0 || if_id_flush !== 1'b0) begin
                failures++;
                $display("FAIL stall_cyc%0d pc_en=%b en=%b flush=%b want 0 0 0",
                         i, pc_en, if_id_en, if_id_flush);
            end
            step();
        end
        stall_req = 1'b0;
        #4;
        checks++;
        if (pc_en !== 1'b1 || if_id_en !== 1'b1 || stall_cnt !== 4'd3) begin
            failures++;
            $display("FAIL stall_release pc_en=%b en=%b sc=%0d want 1 1 3",
                     pc_en, if_id_en, stall_cnt);
        end
        step();
    endtask

    task automatic test_stall_override();
        reset_and_boot();
        stall_req = 1'b1;
        step();
        br_taken = 1'b1; br_target = 32'h0000_0200;
        #4;
        checks++;
        if (pc_en !== 1'b1 || pc_sel !== 1'b1 || npc_alu !== 32'h200) begin
            failures++;
            $display("FAIL stall_override pc_en=%b sel=%b npc=%h want 1 1 00000200",
                     pc_en, pc_sel, npc_alu);
        end
        step();
        br_taken = 1'b0;
        #4;
        checks++;
        if (pc_en !== 1'b1 || if_id_flush !== 1'b1) begin
            failures++;
            $display("FAIL stall_in_flush pc_en=%b flush=%b want 1 1", pc_en, if_id_flush);
        end
        step();
        stall_req = 1'b0;
        #4;
        checks++;
        if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL stall_override_cnt sc=%0d fc=%0d want 1 1", stall_cnt, flush_cnt);
        end
        step();
    endtask

    task automatic test_halt();
        int bad;
        reset_and_boot();
        ir = 32'hFC00_0000;
        #4;
        checks++;
        if (pc_en !== 1'b0 || if_id_en !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_detect pc_en=%b en=%b halted=%b want 0 1 0", pc_en, if_id_en, halted);
        end
        step();
        ir = '0;
        br_taken = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #4;
            if (halted !== 1'b1 || pc_en !== 1'b0 || if_id_en !== 1'b0 || if_id_flush !== 1'b1)
                bad++;
            step();
        end
        br_taken = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL halt_hold bad_cycles=%0d want 0 (halted=%b pc_en=%b)", bad, halted, pc_en);
        end
    endtask

    task automatic test_reset_mid_run();
        reset_and_boot();
        br_taken = 1'b1; br_target = 32'h0000_0010;
        step();
        br_taken = 1'b0;
        #2;
        checks++;
        if (if_id_flush !== 1'b1 || pc_en !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre flush=%b pc_en=%b want 1 1", if_id_flush, pc_en);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pc_en, pc_sel, if_id_en, if_id_flush, halted, lif_a.ld_ready} !== 6'b0 ||
            flush_cnt !== 4'd0 || npc_alu !== 32'h0) begin
            failures++;
            $display("FAIL mid_async ctrl=%b fc=%0d npc=%h want 000000 0 0",
                     {pc_en, pc_sel, if_id_en, if_id_flush, halted, lif_a.ld_ready}, flush_cnt, npc_alu);
        end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (lif_a.ld_ready !== 1'b1 || if_id_flush !== 1'b1 || pc_en !== 1'b0 ||
            stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_release ready=%b flush=%b pc_en=%b sc=%0d fc=%0d want 1 1 0 0 0",
                     lif_a.ld_ready, if_id_flush, pc_en, stall_cnt, flush_cnt);
        end
        step();
    endtask

    task automatic test_saturation();
        reset_and_boot();
        stall_req = 1'b1;
        for (int i = 0; i < 20; i++) step();
        stall_req = 1'b0;
        #4;
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt4 got=%0d want 15", stall_cnt);
        end
        checks++;
        if (b_stall_cnt !== 16'd20) begin
            failures++;
            $display("FAIL sat_cnt16 got=%0d want 20", b_stall_cnt);
        end
        step();
    endtask

    initial begin
        idle_inputs();
        #2 rst_n = 1'b0;
        test_reset();
        test_load();
        test_branch();
        test_stall();
        test_stall_override();
        test_halt();
        test_reset_mid_run();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence never completes
    initial begin
        #100000;
        $display("FAIL timeout sim_time=%0t want completion", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
